// File: rtl/fare_ledger.sv
// -----------------------------------------------------------------------------
// fare_ledger
//   Fare ledger for a transit gate. Keeps a 16-slot table of card entries
//   (active flag + 8-bit balance). A card tap is looked up in one cycle and
//   presented to the gate FSM with a one-cycle nfc pulse. The gate may then
//   request a debit within an 8-cycle window. Top-ups are accepted only while
//   idle and saturate at 255.
//
// Ports
//   clk          : sole clock, rising edge
//   rst_n        : asynchronous active-low reset
//   tap_valid    : card tap reported this cycle
//   tap_id[3:0]  : card slot of the tap
//   fare[7:0]    : fare, sampled together with the tap
//   reduce_bal   : debit request from the gate FSM
//   topup_valid  : top-up request
//   topup_id[3:0]: card slot to top up
//   topup_amt[7:0]: amount to add
//   topup_ready  : high only in IDLE (top-up handshake)
//   nfc          : one-cycle tap notification (PRESENT state)
//   card_active  : tapped card is registered
//   fund_enough  : tapped card is active and balance >= fare
//   debit_done   : one-cycle pulse when the debit commits
//   bal_out[7:0] : balance of the tapped card (post-debit during DEBIT)
//   busy         : high in any state other than IDLE
// -----------------------------------------------------------------------------
module fare_ledger (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tap_valid,
    input  logic [3:0] tap_id,
    input  logic [7:0] fare,
    input  logic       reduce_bal,
    input  logic       topup_valid,
    input  logic [3:0] topup_id,
    input  logic [7:0] topup_amt,
    output logic       topup_ready,
    output logic       nfc,
    output logic       card_active,
    output logic       fund_enough,
    output logic       debit_done,
    output logic [7:0] bal_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        PRESENT,
        WAIT_DEBIT,
        DEBIT
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  fare_q, fare_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        card_q, card_d;
    logic        fund_q, fund_d;
    logic [7:0]  bal_out_q, bal_out_d;
    logic        debit_wr;

    // Card table
    logic [15:0] active_q;
    logic [7:0]  bal_q [16];

    logic        topup_accept;
    logic [8:0]  topup_sum;
    logic [7:0]  topup_sat;

    assign topup_accept = topup_valid && (state_q == IDLE);
    assign topup_sum    = {1'b0, bal_q[topup_id]} + {1'b0, topup_amt};
    assign topup_sat    = topup_sum[8] ? 8'hFF : topup_sum[7:0];

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d   = state_q;
        id_d      = id_q;
        fare_d    = fare_q;
        cnt_d     = cnt_q;
        card_d    = card_q;
        fund_d    = fund_q;
        bal_out_d = bal_out_q;
        debit_wr  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tap_valid) begin
                    id_d    = tap_id;
                    fare_d  = fare;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                // The table already holds any top-up accepted alongside the tap.
                card_d    = active_q[id_q];
                fund_d    = active_q[id_q] && (bal_q[id_q] >= fare_q);
                bal_out_d = bal_q[id_q];
                state_d   = PRESENT;
            end
            PRESENT: begin
                cnt_d   = 3'd0;
                state_d = WAIT_DEBIT;
            end
            WAIT_DEBIT: begin
                if (reduce_bal && fund_q) begin
                    // fund_q guarantees bal_out_q >= fare_q, so no underflow.
                    bal_out_d = bal_out_q - fare_q;
                    state_d   = DEBIT;
                end else if (cnt_q == 3'd7) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DEBIT: begin
                debit_wr = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Presented results are cleared whenever the block (re)enters IDLE.
        if (state_d == IDLE) begin
            card_d    = 1'b0;
            fund_d    = 1'b0;
            bal_out_d = 8'd0;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q      <= 4'd0;
            fare_q    <= 8'd0;
            cnt_q     <= 3'd0;
            card_q    <= 1'b0;
            fund_q    <= 1'b0;
            bal_out_q <= 8'd0;
        end else begin
            id_q      <= id_d;
            fare_q    <= fare_d;
            cnt_q     <= cnt_d;
            card_q    <= card_d;
            fund_q    <= fund_d;
            bal_out_q <= bal_out_d;
        end
    end

    // -------------------------------------------------------------------------
    // Card table. Debit writes happen only in DEBIT and top-ups only in IDLE,
    // so the two write ports never collide.
    // -------------------------------------------------------------------------
    // NOTE: the table is cleared by reset because a reset must leave every
    // card inactive with a zero balance; this keeps it in flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                bal_q[i] <= 8'd0;
            end
        end else begin
            if (debit_wr) begin
                bal_q[id_q] <= bal_out_q;
            end
            if (topup_accept) begin
                active_q[topup_id] <= 1'b1;
                bal_q[topup_id]    <= topup_sat;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign topup_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign nfc         = (state_q == PRESENT);
    assign debit_done  = (state_q == DEBIT);
    assign card_active = card_q;
    assign fund_enough = fund_q;
    assign bal_out     = bal_out_q;

endmodule
